// File: rtl/alu_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : alu_req_arbiter_if
// Brief  : Request/response and shared-ALU bundle for alu_req_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_req_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_instr;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic [3:0]            alu_instr;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_result;

  // master is the surrounding environment: issue logic plus the alu result path
  modport master (
    output req_valid, req_a, req_b, req_instr, rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_result, alu_instr, alu_a, alu_b
  );

  modport slave (
    input  req_valid, req_a, req_b, req_instr, rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_result, alu_instr, alu_a, alu_b
  );
endinterface
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_req_arbiter
// Brief  : Shares one alu_control/alu pair between NREQ requesters.
//          Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Rev    : 1.0  initial release
// ============================================================================
module alu_req_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_req_arbiter_if.slave   bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_grant;
  logic [PW-1:0]     w_base;
  logic [PW-1:0]     w_win;
  logic              w_found;
  logic              w_accept;
  logic              w_release;
  logic [NREQ-1:0]   w_req_ready;
  logic [NREQ-1:0]   w_rsp_valid;
  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic [3:0]        r_alu_instr;
  logic [WIDTH-1:0]  r_rsp_result;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [PW-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_release) begin
      r_rr_ptr <= (r_grant == PW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end

  assign w_base = r_rr_ptr;
`endif

  // Search upward from the base pointer, wrapping past NREQ-1 back to 0.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(w_base) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && bus.req_valid[PW'(idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_grant <= w_win;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept           = 1'b1;
          w_req_ready[w_win] = 1'b1;
          w_next             = S_EXEC;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        w_rsp_valid[r_grant] = 1'b1;
        if (bus.rsp_ready[r_grant]) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand registers are loaded only on accept and otherwise keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_instr  <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a     <= bus.req_a[int'(w_win)*WIDTH +: WIDTH];
        r_alu_b     <= bus.req_b[int'(w_win)*WIDTH +: WIDTH];
        r_alu_instr <= bus.req_instr[int'(w_win)*4 +: 4];
      end
      if (r_state == S_EXEC) r_rsp_result <= bus.alu_result;
    end
  end

  // Reset forces IDLE, which could otherwise still raise req_ready from live requests.
  assign bus.req_ready  = rst_n ? w_req_ready : '0;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_instr  = r_alu_instr;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_req_arbiter
// Brief  : Directed self-checking bench for alu_req_arbiter with a small ALU model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_req_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_req_arbiter_if #(.WIDTH(16), .NREQ(2)) bus ();

  alu_req_arbiter #(.WIDTH(16), .NREQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [15:0] a, b, input logic [3:0] ins);
    case (ins)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_instr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, b, input logic [3:0] ins);
    bus.req_a[i*16 +: 16]   = a;
    bus.req_b[i*16 +: 16]   = b;
    bus.req_instr[i*4 +: 4] = ins;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  logic [1:0] exp_g;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_instr = '0;
    bus.rsp_ready = 2'b00;
    step();
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    #1;

    // Test 1: req0 add
    set_req(0, 16'h0001, 16'h0002, 4'b0000);
    bus.req_valid = 2'b01;
    #1 chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 2'b00;
    #1 chk("t1_exec_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t1_alu_a", 32'(bus.alu_a), 32'h1);
    chk("t1_alu_b", 32'(bus.alu_b), 32'h2);
    step();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_result", 32'(bus.rsp_result), 32'h0003);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    #1 chk("t1_done_rsp_valid", 32'(bus.rsp_valid), 32'h0);

    // Test 2: req1 sub
    set_req(1, 16'h0001, 16'h0002, 4'b1000);
    bus.req_valid = 2'b10;
    #1 chk("t2_req_ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t2_rsp_result", 32'(bus.rsp_result), 32'hFFFF);
    bus.rsp_ready = 2'b10;
    step();

    // Test 3: both valid after reset, req0 first
    do_reset();
    bus.rsp_ready = 2'b11;
    set_req(0, 16'h00F0, 16'h0FF0, 4'b0111);
    set_req(1, 16'h00F0, 16'h0FF0, 4'b0110);
    bus.req_valid = 2'b11;
    #1 chk("t3_first_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 2'b10;
    step();
    chk("t3_rsp0_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t3_rsp0_result", 32'(bus.rsp_result), 32'h00F0);
    step();
    chk("t3_second_ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t3_rsp1_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t3_rsp1_result", 32'(bus.rsp_result), 32'h0FF0);
    step();

    // Test 4: both continuously valid, grants alternate (or stay on 0 under fixed priority)
    set_req(0, 16'h0005, 16'h0003, 4'b0000);
    set_req(1, 16'h00FF, 16'h0F0F, 4'b0100);
    bus.req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
      #1 chk("t4_grant", 32'(bus.req_ready), 32'(exp_g));
      step();
      chk("t4_exec_no_ready", 32'(bus.req_ready), 32'h0);
      step();
      chk("t4_resp_no_ready", 32'(bus.req_ready), 32'h0);
      chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
      chk("t4_result", 32'(bus.rsp_result), (exp_g == 2'b01) ? 32'h0008 : 32'h0FF0);
      step();
    end
    bus.req_valid = 2'b00;

    // Test 5: response stall, non-granted rsp_ready ignored
    do_reset();
    set_req(0, 16'h1234, 16'h1111, 4'b0000);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b11;
    step();
    bus.rsp_ready = 2'b10;
    for (int n = 0; n < 5; n++) begin
      #1 chk("t5_hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t5_hold_result", 32'(bus.rsp_result), 32'h2345);
      chk("t5_no_ready", 32'(bus.req_ready), 32'h0);
      step();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    step();
    chk("t5_release", 32'(bus.rsp_valid), 32'h0);
    bus.rsp_ready = 2'b11;

    // Undefined encoding passes straight through to the alu
    set_req(0, 16'h0007, 16'h0009, 4'b1111);
    set_req(1, 16'h0007, 16'h0009, 4'b1111);
    bus.req_valid = 2'b11;
    step();
    bus.req_valid = 2'b00;
    chk("undef_alu_instr", 32'(bus.alu_instr), 32'hF);
    step();
    chk("undef_result", 32'(bus.rsp_result), 32'h0);
    step();

    // Test 6: reset during EXEC
    set_req(0, 16'hAAAA, 16'h5555, 4'b0110);
    bus.req_valid = 2'b01;
    step();
    chk("t6_in_exec_alu_a", 32'(bus.alu_a), 32'hAAAA);
    rst_n = 1'b0;
    #1 chk("t6_rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("t6_rst_alu_instr", 32'(bus.alu_instr), 32'h0);
    chk("t6_rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    step();
    rst_n = 1'b1;
    #1 chk("t6_idle_after", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
